// File: rtl/ballot_unit_if.sv
// ballot_unit_if: groups the voter/officer inputs and the vote/status outputs
// of ballot_unit. The slave modport is the unit itself; master is its driver.
interface ballot_unit_if;
    logic       ballot_issue;
    logic [4:0] btn;
    logic       vo_en;
    logic [4:0] vo_switch;
    logic       ready_led;
    logic       multi_press;
    logic       timeout;
    logic [7:0] cast_count;

    modport master (
        output ballot_issue,
        output btn,
        input  vo_en,
        input  vo_switch,
        input  ready_led,
        input  multi_press,
        input  timeout,
        input  cast_count
    );

    modport slave (
        input  ballot_issue,
        input  btn,
        output vo_en,
        output vo_switch,
        output ready_led,
        output multi_press,
        output timeout,
        output cast_count
    );
endinterface

// File: rtl/ballot_unit.sv
// ballot_unit: one-vote-per-ballot capture of five voter buttons.
// A ballot released by the presiding officer arms the unit; a button pattern
// must stay stable for DEBOUNCE_CYCLES samples before it is accepted. A single
// pressed button casts one vote strobe, several pressed buttons are rejected
// and the ballot stays armed. All outputs are registered.
// Optional feature: define TIMEOUT_EN to build a 16-bit timer that voids an
// armed ballot after TIMEOUT_CYCLES cycles.
module ballot_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic         clk,
    input  logic         rst,
    ballot_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_DEBOUNCE = 3'd2,
        S_CAST     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    // Counter value on which a still-equal pattern is accepted: the capture
    // sample plus DEBOUNCE_CYCLES-1 further equal samples.
    localparam logic [3:0] ACCEPT_AT = 4'(DEBOUNCE_CYCLES - 2);

    state_t     state_q,     state_d;
    logic [4:0] pattern_q,   pattern_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       armed_q,     armed_d;
    logic       vo_en_q,     vo_en_d;
    logic [4:0] vo_switch_q, vo_switch_d;
    logic       ready_q,     ready_d;
    logic       multi_q,     multi_d;
    logic       timeout_q,   timeout_d;
    logic [7:0] cast_q,      cast_d;
    logic       expire;
    logic       accept;

`ifdef TIMEOUT_EN
    logic [15:0] tmr_q, tmr_d;
    logic [16:0] tmr_inc;
    logic        tmr_run;

    // The timer runs whenever a ballot is armed: waiting, debouncing, or
    // waiting for release after a rejected multi-press.
    assign tmr_run = (state_q == S_ARMED) || (state_q == S_DEBOUNCE) ||
                     ((state_q == S_RELEASE) && armed_q);
    assign tmr_inc = {1'b0, tmr_q} + 17'd1;
    assign expire  = tmr_run && (tmr_inc >= 17'(TIMEOUT_CYCLES));

    // Timer next value: held clear in IDLE so arming starts from zero; it
    // holds on expiry so a ballot kept alive by a same-cycle acceptance
    // expires again on the next armed cycle.
    always_comb begin
        tmr_d = tmr_q;
        if (state_q == S_IDLE) begin
            tmr_d = '0;
        end else if (tmr_run && !expire) begin
            tmr_d = tmr_inc[15:0];
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Ballot FSM next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        cast_d      = cast_q;
        vo_en_d     = 1'b0;
        vo_switch_d = '0;
        multi_d     = 1'b0;
        timeout_d   = 1'b0;
        ready_d     = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A button already held when the ballot is released blocks arming.
                if (bus.ballot_issue && (bus.btn == 5'd0)) begin
                    state_d = S_ARMED;
                    armed_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (bus.btn != 5'd0) begin
                    pattern_d = bus.btn;
                    cnt_d     = '0;
                    state_d   = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (bus.btn == pattern_q) begin
                    if (cnt_q == ACCEPT_AT) begin
                        accept = 1'b1;
                        cnt_d  = '0;
                        if ($onehot(pattern_q)) begin
                            state_d     = S_CAST;
                            armed_d     = 1'b0;
                            vo_en_d     = 1'b1;
                            vo_switch_d = pattern_q;
                            if (cast_q != 8'hFF) begin
                                cast_d = cast_q + 8'd1;
                            end
                        end else begin
                            state_d = S_RELEASE;
                            multi_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (bus.btn == 5'd0) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    pattern_d = bus.btn;
                    cnt_d     = '0;
                end
            end
            S_CAST: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (bus.btn == 5'd0) begin
                    state_d = armed_q ? S_ARMED : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                armed_d = 1'b0;
            end
        endcase

        // Expiry voids the ballot, but an acceptance on the same cycle wins.
        if (expire && !accept) begin
            state_d   = S_IDLE;
            armed_d   = 1'b0;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end

        ready_d = (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
    end

    // Ballot FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pattern_q   <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            cast_q      <= '0;
            vo_en_q     <= 1'b0;
            vo_switch_q <= '0;
            ready_q     <= 1'b0;
            multi_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            cast_q      <= cast_d;
            vo_en_q     <= vo_en_d;
            vo_switch_q <= vo_switch_d;
            ready_q     <= ready_d;
            multi_q     <= multi_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.vo_en       = vo_en_q;
    assign bus.vo_switch   = vo_switch_q;
    assign bus.ready_led   = ready_q;
    assign bus.multi_press = multi_q;
    assign bus.timeout     = timeout_q;
    assign bus.cast_count  = cast_q;
endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: randomized and directed stimulus for ballot_unit with a
// scoreboard. A reference model, written in terms of ballots, button runs and
// release waits, predicts vote / multi-press / timeout events and ready_led;
// a monitor on the falling edge compares the DUT against those predictions.
module tb_ballot_unit;
    localparam int unsigned DC = 4;
`ifdef TIMEOUT_EN
    localparam int unsigned TC = 20;
`else
    localparam int unsigned TC = 1000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ballot_unit_if bif();

    ballot_unit #(
        .DEBOUNCE_CYCLES(DC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    // kind: 0 vote, 1 multi-press, 2 timeout
    typedef struct {
        int kind;
        int pat;
        int cnt;
        int cyc;
    } ev_t;

    ev_t sbq[$];
    bit  exp_ready [int];

    // Reference model state
    bit m_avail;      // a ballot is issued and not yet consumed or voided
    bit m_listen;     // presses are being observed
    bit m_deaf;       // a decision was taken; waiting for all buttons released
    int m_deaf_from;  // first cycle on which a release can be recognised
    int m_idle_from;  // first cycle on which a new ballot release is honoured
    int m_run_pat;
    int m_run_len;
    int m_arm_cyc;
    int m_cnt;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset(input int start);
        m_avail     = 1'b0;
        m_listen    = 1'b0;
        m_deaf      = 1'b0;
        m_deaf_from = 0;
        m_idle_from = start;
        m_run_pat   = 0;
        m_run_len   = 0;
        m_arm_cyc   = 0;
        m_cnt       = 0;
    endfunction

    // Inputs of cycle c are sampled at the end of c; predicted pulses appear in c+1.
    function automatic void model_step(input int c, input bit iss, input int b);
        bit  acc;
        ev_t e;
        acc = 1'b0;
        e   = '{kind: 0, pat: 0, cnt: 0, cyc: 0};
        if (m_deaf) begin
            if (c >= m_deaf_from && b == 0) begin
                m_deaf = 1'b0;
                if (m_avail) begin
                    m_listen  = 1'b1;
                    m_run_len = 0;
                end else begin
                    m_idle_from = c + 1;
                end
            end
        end else if (!m_avail) begin
            if (c >= m_idle_from && iss && b == 0) begin
                m_avail   = 1'b1;
                m_listen  = 1'b1;
                m_run_len = 0;
                m_arm_cyc = c;
            end
        end else if (m_listen) begin
            if (b == 0) begin
                m_run_len = 0;
            end else if (m_run_len > 0 && b == m_run_pat) begin
                m_run_len++;
            end else begin
                m_run_pat = b;
                m_run_len = 1;
            end
            if (m_run_len == int'(DC)) begin
                acc       = 1'b1;
                m_listen  = 1'b0;
                m_deaf    = 1'b1;
                m_run_len = 0;
                e.pat     = m_run_pat;
                e.cyc     = c + 1;
                if ($countones(m_run_pat) == 1) begin
                    if (m_cnt < 255) m_cnt++;
                    e.kind      = 0;
                    e.cnt       = m_cnt;
                    m_avail     = 1'b0;
                    m_deaf_from = c + 2;
                end else begin
                    e.kind      = 1;
                    e.cnt       = m_cnt;
                    m_deaf_from = c + 1;
                end
                sbq.push_back(e);
            end
        end
`ifdef TIMEOUT_EN
        if (m_avail && !acc && c >= m_arm_cyc + int'(TC)) begin
            e.kind = 2;
            e.pat  = 0;
            e.cnt  = m_cnt;
            e.cyc  = c + 1;
            sbq.push_back(e);
            m_avail     = 1'b0;
            m_listen    = 1'b0;
            m_deaf      = 1'b0;
            m_idle_from = c + 1;
        end
`endif
        exp_ready[c + 1] = m_avail && m_listen && !acc;
    endfunction

    task automatic drive(input bit iss, input logic [4:0] b);
        bif.ballot_issue = iss;
        bif.btn          = b;
        model_step(cyc, iss, int'(b));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_vo_en"},       int'(bif.vo_en),       0);
        chk({tag, "_vo_switch"},   int'(bif.vo_switch),   0);
        chk({tag, "_ready_led"},   int'(bif.ready_led),   0);
        chk({tag, "_multi_press"}, int'(bif.multi_press), 0);
        chk({tag, "_timeout"},     int'(bif.timeout),     0);
        chk({tag, "_cast_count"},  int'(bif.cast_count),  0);
        sbq.delete();
        exp_ready.delete();
        bif.ballot_issue = 1'b0;
        bif.btn          = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset(cyc);
    endtask

    task automatic vote_once(input logic [4:0] p);
        drive(1'b1, 5'd0);
        drive(1'b0, 5'd0);
        repeat (DC) drive(1'b0, p);
        repeat (3) drive(1'b0, 5'd0);
    endtask

    // Scoreboard monitor: compares every presented pulse with the oldest prediction.
    always @(negedge clk) begin
        int  n;
        int  kind;
        ev_t e;
        if (mon_en && rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("missing_event_cycle", cyc, e.cyc);
            end
            n = int'(bif.vo_en) + int'(bif.multi_press) + int'(bif.timeout);
            if (n > 1) chk("single_pulse", n, 1);
            if (n > 0) begin
                kind = bif.vo_en ? 0 : (bif.multi_press ? 1 : 2);
                if (sbq.size() == 0) begin
                    chk("unexpected_event_kind", kind, -1);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind",  kind, e.kind);
                    chk("event_cycle", cyc,  e.cyc);
                    if (kind == 0) begin
                        chk("vo_switch",          int'(bif.vo_switch),  e.pat);
                        chk("cast_count_at_vote", int'(bif.cast_count), e.cnt);
                    end
                end
            end
            if (!bif.vo_en) chk("vo_switch_idle", int'(bif.vo_switch), 0);
            if (exp_ready.exists(cyc)) chk("ready_led", int'(bif.ready_led), int'(exp_ready[cyc]));
        end
    end

    initial begin
        bif.ballot_issue = 1'b0;
        bif.btn          = 5'd0;
        model_reset(0);
        #2;
        apply_reset("por");
        mon_en = 1'b1;

        // Single valid press held exactly DEBOUNCE_CYCLES cycles
        drive(1'b1, 5'd0);
        drive(1'b0, 5'd0);
        repeat (DC) drive(1'b0, 5'b00100);
        repeat (4) drive(1'b0, 5'd0);
        chk("cast_count_first_vote", int'(bif.cast_count), 1);

        // Held button with repeated ballot releases: must stay idle
        repeat (3) begin
            drive(1'b1, 5'b00100);
            drive(1'b0, 5'b00100);
        end
        repeat (3) drive(1'b0, 5'd0);
        chk("cast_count_blocked", int'(bif.cast_count), 1);

        // Short bounce then a stable different press
        drive(1'b1, 5'd0);
        drive(1'b0, 5'd0);
        repeat (2) drive(1'b0, 5'b00001);
        drive(1'b0, 5'd0);
        repeat (DC) drive(1'b0, 5'b00010);
        repeat (4) drive(1'b0, 5'd0);
        chk("cast_count_after_bounce", int'(bif.cast_count), 2);

        // Multi-press rejection, ballot survives, then NOTA vote
        drive(1'b1, 5'd0);
        drive(1'b0, 5'd0);
        repeat (DC) drive(1'b0, 5'b01001);
        repeat (3) drive(1'b0, 5'd0);
        repeat (DC) drive(1'b0, 5'b10000);
        repeat (4) drive(1'b0, 5'd0);
        chk("cast_count_after_multi", int'(bif.cast_count), 3);

        // Reset while debouncing voids the ballot
        drive(1'b1, 5'd0);
        drive(1'b0, 5'd0);
        repeat (2) drive(1'b0, 5'b00010);
        chk("ready_before_reset", int'(bif.ready_led), 1);
        apply_reset("mid_debounce");
        repeat (DC + 2) drive(1'b0, 5'b00010);
        repeat (2) drive(1'b0, 5'd0);

        // Randomized button runs and ballot releases
        for (int s = 0; s < 400; s++) begin
            int         len;
            logic [4:0] p;
            len = $urandom_range(1, DC + 2);
            case ($urandom_range(0, 3))
                0:       p = 5'd0;
                1, 2:    p = 5'(1 << $urandom_range(0, 4));
                default: p = 5'($urandom);
            endcase
            for (int k = 0; k < len; k++) drive($urandom_range(0, 3) == 0, p);
        end
        repeat (5) drive(1'b0, 5'd0);

        // Drive the tally to saturation and one vote beyond
        for (int v = 0; v < 300 && m_cnt < 255; v++) vote_once(5'(1 << $urandom_range(0, 4)));
        vote_once(5'b00001);
        chk("cast_count_saturated", int'(bif.cast_count), 255);

        // Reset in the very cycle the vote strobe is presented
        drive(1'b1, 5'd0);
        drive(1'b0, 5'd0);
        repeat (DC) drive(1'b0, 5'b01000);
        chk("vo_en_before_cast_reset", int'(bif.vo_en), 1);
        apply_reset("mid_cast");
        repeat (DC + 2) drive(1'b0, 5'b01000);
        repeat (4) drive(1'b0, 5'd0);
        chk("cast_count_after_cast_reset", int'(bif.cast_count), 0);

`ifdef TIMEOUT_EN
        // Armed ballot with no press expires; a later press is not a vote
        drive(1'b1, 5'd0);
        repeat (TC + 3) drive(1'b0, 5'd0);
        repeat (DC + 1) drive(1'b0, 5'b00100);
        repeat (4) drive(1'b0, 5'd0);
        chk("cast_count_after_timeout", int'(bif.cast_count), 0);
`endif

        repeat (6) drive(1'b0, 5'd0);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable cycles a button pattern must hold before it is accepted (legal range 2..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, cycles an issued ballot stays armed before it is voided (legal range 2..65535; used only with TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ballot_issue  input  1  presiding-officer ballot release; level sampled each cycle.
REQ-006 btn  input  5  raw voter buttons; bits 0..3 map to parties 1..4 and bit 4 to NOTA; assumed already synchronised to clk.
REQ-007 vo_en  output  1  one-cycle vote strobe to the downstream tally stage.
REQ-008 vo_switch  output  5  one-hot vote choice; valid only while vo_en=1, else 0.
REQ-009 ready_led  output  1  high while a ballot is armed (ARMED or DEBOUNCE).
REQ-010 multi_press  output  1  one-cycle pulse when a stable pattern with 2+ bits set is rejected.
REQ-011 timeout  output  1  one-cycle pulse when an armed ballot is voided by timeout.
REQ-012 cast_count  output  8  ballots successfully cast since reset; saturates at 255.

Function
REQ-013 The FSM SHALL have states IDLE, ARMED, DEBOUNCE, CAST, RELEASE.
REQ-014 IDLE: when ballot_issue=1 and btn=0, go to ARMED next cycle; a held button blocks arming; ballot_issue is ignored in all other states.
REQ-015 ARMED: when btn is non-zero, capture btn into a pattern register, clear the stability counter, and go to DEBOUNCE.
REQ-016 DEBOUNCE: each cycle btn equals the captured pattern, increment the counter; if btn differs, go to ARMED (btn=0) or recapture and restart (btn non-zero, different).
REQ-017 Acceptance SHALL occur on the cycle the counter reaches DEBOUNCE_CYCLES-1 with btn still equal, giving DEBOUNCE_CYCLES stable cycles including the capture cycle.
REQ-018 An accepted one-hot pattern SHALL go to CAST; an accepted pattern with 2+ bits set SHALL pulse multi_press and go to RELEASE with the ballot still armed.
REQ-019 CAST SHALL last exactly one cycle with vo_en=1 and vo_switch equal to the pattern, increment cast_count (saturating), then go to RELEASE with the ballot consumed.
REQ-020 RELEASE: wait until btn=0 for one cycle, then go to ARMED if the ballot is still armed (after a multi-press), else to IDLE.
REQ-021 vo_en SHALL be 0 and vo_switch SHALL be 0 in every state except CAST; at most one vo_en pulse per ballot_issue.
REQ-022 Latency from the first cycle of a stable valid press to the vo_en cycle SHALL be DEBOUNCE_CYCLES cycles (vo_en asserted on cycle DEBOUNCE_CYCLES after the capture edge).
REQ-023 cast_count at 255 SHALL remain 255 when a further vote is cast; vo_en is still issued.

Reset
REQ-024 Asserting rst low SHALL immediately force IDLE, clear the pattern and counters, and drive vo_en=0, vo_switch=0, ready_led=0, multi_press=0, timeout=0, cast_count=0.
REQ-025 Reset mid-ballot (any state, including CAST) SHALL void the ballot with no vo_en issued after reset release; a new ballot_issue is required.

Configuration
REQ-026 Macro TIMEOUT_EN: when defined, a 16-bit timer SHALL clear on entry to ARMED from IDLE and count every cycle in ARMED, DEBOUNCE, or RELEASE-while-armed; on reaching TIMEOUT_CYCLES the ballot is voided, timeout pulses, and the FSM goes to IDLE.
REQ-027 With TIMEOUT_EN, if acceptance and timeout expiry occur in the same cycle, acceptance SHALL win (vote cast, no timeout pulse).
REQ-028 Without TIMEOUT_EN, no timer SHALL be built, timeout SHALL be tied 0, and an armed ballot stays armed indefinitely.

Verification
REQ-029 Reset, issue ballot, hold btn=5'b00100 for 4 cycles -> single vo_en pulse with vo_switch=5'b00100 on cycle 4, cast_count=1, ready_led drops.
REQ-030 Armed, btn=00001 for 2 cycles, 0 for 1 cycle, then 00010 for 4 cycles -> no vote for 00001; one vo_en with 00010.
REQ-031 Armed, btn=01001 held 4 cycles -> multi_press pulse, no vo_en; release, then 10000 held 4 cycles -> vo_en with 10000.
REQ-032 After cast, hold btn and pulse ballot_issue repeatedly without release -> no further vo_en, stays IDLE; cast_count unchanged.
REQ-033 TIMEOUT_EN, TIMEOUT_CYCLES=20, issue ballot and no press -> timeout pulse 20 cycles after arming, IDLE; a later press gives no vo_en.
REQ-034 Preload cast_count to 255 via 255 votes, cast one more -> vo_en issued, cast_count=255; assert rst during DEBOUNCE -> all outputs 0 immediately.
